// File: rtl/tribus_pkg.sv
// rtl/tribus_pkg.sv - shared types and width helpers for the tristate bus driver
package tribus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // Index width for n channels; never narrower than one bit
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold values 0..maxval; never narrower than one bit
  function automatic int cnt_w(input int maxval);
    return (maxval > 0) ? $clog2(maxval + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting after the pointer
module rr_pick
  import tribus_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int OW       = owner_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [OW-1:0]       ptr_i,
  output logic                found_o,
  output logic [OW-1:0]       idx_o
);

  // Scan ptr+1, ptr+2, ... wrapping, so the last winner gets lowest priority
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      if (!found_o && req_i[(int'(ptr_i) + i) % CHANNELS]) begin
        found_o = 1'b1;
        idx_o   = OW'((int'(ptr_i) + i) % CHANNELS);
      end
    end
  end

endmodule

// File: rtl/tribus_rr_driver.sv
// rtl/tribus_rr_driver.sv - round-robin owner of a shared tristate bus with turnaround gap
module tribus_rr_driver
  import tribus_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int TURNAROUND = 1,
  parameter int HOLD_MAX   = 4,
  parameter int INVERT     = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHANNELS-1:0]           req,
  input  logic [CHANNELS*WIDTH-1:0]     data,
  output logic [CHANNELS-1:0]           gnt,
  output logic [owner_w(CHANNELS)-1:0]  owner,
  output logic                          bus_en,
  output logic                          busy,
  inout  wire  [WIDTH-1:0]              bus
);

  localparam int OW = owner_w(CHANNELS);
  localparam int HW = cnt_w(HOLD_MAX);
  localparam int TW = cnt_w(TURNAROUND);

  state_t              state_q;
  logic [CHANNELS-1:0] gnt_q;
  logic [OW-1:0]       owner_q;
  logic [OW-1:0]       ptr_q;
  logic [HW-1:0]       hold_q;
  logic [TW-1:0]       turn_q;
  logic [WIDTH-1:0]    data_q;

  logic [WIDTH-1:0]    chan_data [CHANNELS];
  logic                pick_found;
  logic [OW-1:0]       pick_idx;
  logic                release_now;
  logic [WIDTH-1:0]    drive_d;

  // Unpack the flat data port into per-channel words
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      chan_data[k] = data[k*WIDTH +: WIDTH];
    end
  end

  rr_pick #(
    .CHANNELS (CHANNELS),
    .OW       (OW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Owner gives up the bus when it drops req or its tenure hits the hold limit
  always_comb begin
    release_now = !req[owner_q];
    if (HOLD_MAX != 0 && hold_q == HW'(HOLD_MAX)) begin
      release_now = 1'b1;
    end
  end

  // Arbitration FSM; grant, owner and data are all registered here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= OW'(CHANNELS - 1);
      hold_q  <= '0;
      turn_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q <= GRANT;
            gnt_q   <= CHANNELS'(1) << pick_idx;
            owner_q <= pick_idx;
            ptr_q   <= pick_idx;
            data_q  <= chan_data[pick_idx];
            hold_q  <= HW'(1);
          end
        end
        GRANT: begin
          data_q <= chan_data[owner_q];
          if (release_now) begin
            gnt_q <= '0;
            if (TURNAROUND > 0) begin
              state_q <= TURN;
              turn_q  <= TW'(1);
            end else begin
              state_q <= IDLE;
            end
          end else if (HOLD_MAX != 0) begin
            hold_q <= hold_q + HW'(1);
          end
        end
        TURN: begin
          if (turn_q == TW'(TURNAROUND)) begin
            state_q <= IDLE;
          end else begin
            turn_q <= turn_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Only GRANT drives the bus, so gnt and bus_en always agree
  always_comb begin
    drive_d = (INVERT != 0) ? ~data_q : data_q;
  end

  assign gnt    = gnt_q;
  assign owner  = owner_q;
  assign bus_en = (state_q == GRANT);
  assign busy   = (state_q != IDLE);
  assign bus    = bus_en ? drive_d : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tribus_rr_driver.sv
// tb/tb_tribus_rr_driver.sv - scoreboard bench for tribus_rr_driver
module tb_tribus_rr_driver;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int TA = 1;
  localparam int HM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [CH-1:0] req;
  logic [CH*W-1:0] data;

  logic [CH-1:0] gnt, gnt_v;
  logic [1:0]    owner, owner_v;
  logic          bus_en, bus_en_v, busy, busy_v;
  wire  [W-1:0]  bus, bus_v;

  tribus_rr_driver #(
    .WIDTH(W), .CHANNELS(CH), .TURNAROUND(TA), .HOLD_MAX(HM), .INVERT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data),
    .gnt(gnt), .owner(owner), .bus_en(bus_en), .busy(busy), .bus(bus)
  );

  tribus_rr_driver #(
    .WIDTH(W), .CHANNELS(CH), .TURNAROUND(TA), .HOLD_MAX(HM), .INVERT(1)
  ) dut_inv (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data),
    .gnt(gnt_v), .owner(owner_v), .bus_en(bus_en_v), .busy(busy_v), .bus(bus_v)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       bus_en;
    logic       busy;
    logic [7:0] bus;
    logic [7:0] bus_inv;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Tenure log kept by the monitor: who owned the bus and when
  int t_owner[$];
  int t_start[$];
  int t_end[$];
  logic [CH-1:0] prev_gnt = '0;

  // Reference model: bus tenure bookkeeping
  bit   m_granted;
  int   m_owner, m_ptr, m_held, m_block;
  logic [7:0] m_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_granted = 0; m_owner = 0; m_ptr = CH - 1; m_held = 0; m_block = 0; m_data = '0;
    end else if (m_granted) begin
      if (!req[m_owner] || m_held == HM) begin
        m_granted = 0;
        m_block   = TA;
      end else begin
        m_held++;
        m_data = data[m_owner*W +: W];
      end
    end else if (m_block > 0) begin
      m_block--;
    end else begin
      for (int i = 1; i <= CH; i++) begin
        if (!m_granted && req[(m_ptr + i) % CH]) begin
          m_granted = 1;
          m_owner   = (m_ptr + i) % CH;
          m_ptr     = m_owner;
          m_held    = 1;
          m_data    = data[m_owner*W +: W];
        end
      end
    end
  endtask

  task automatic step(input logic [CH-1:0] r, input bit do_rst, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    req   = r;
    rst_n = !do_rst;
    data  = d;
    model_step();
    e.gnt     = m_granted ? 4'(1 << m_owner) : 4'b0;
    e.owner   = 2'(m_owner);
    e.bus_en  = m_granted;
    e.busy    = m_granted || (m_block > 0);
    e.bus     = m_granted ? m_data : 8'hzz;
    e.bus_inv = m_granted ? ~m_data : 8'hzz;
    sb_q.push_back(e);
  endtask

  task automatic clear_log();
    t_owner.delete();
    t_start.delete();
    t_end.delete();
  endtask

  // Monitor: pops one expectation per cycle and logs tenures
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (prev_gnt === '0 && gnt !== '0) begin
      t_owner.push_back(int'(owner));
      t_start.push_back(cyc);
    end
    if (prev_gnt !== '0 && gnt === '0) t_end.push_back(cyc);
    prev_gnt = gnt;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("gnt",     32'(gnt),      32'(e.gnt));
      chk("owner",   32'(owner),    32'(e.owner));
      chk("bus_en",  32'(bus_en),   32'(e.bus_en));
      chk("busy",    32'(busy),     32'(e.busy));
      chk("bus",     {24'h0, bus},  {24'h0, e.bus});
      chk("bus_inv", {24'h0, bus_v}, {24'h0, e.bus_inv});
      chk("gnt_inv", 32'(gnt_v),    32'(e.gnt));
    end
  end

  initial begin
    logic [CH-1:0] r;
    int exp_own [4];
    exp_own = '{0, 1, 3, 0};
    req = '0; data = '0; rst_n = 1'b0;

    // Reset with all channels requesting
    step(4'b1111, 1, $urandom);
    step(4'b1111, 1, $urandom);

    // Single tenure on channel 2 with A5
    clear_log();
    step(4'b0100, 0, 32'h00A5_0000);
    step(4'b0100, 0, 32'h00A5_0000);
    for (int i = 0; i < 4; i++) step(4'b0000, 0, 32'h00A5_0000);
    if (t_owner.size() >= 1 && t_end.size() >= 1) begin
      chk("single_owner", 32'(t_owner[0]), 32'd2);
      chk("single_len", 32'(t_end[0] - t_start[0]), 32'd2);
    end else chk("single_seen", 32'(t_owner.size()), 32'd1);

    // Round robin with hold timeout
    step(4'b0000, 1, $urandom);
    step(4'b0000, 1, $urandom);
    clear_log();
    for (int i = 0; i < 30; i++) step(4'b1011, 0, $urandom);
    if (t_owner.size() >= 4 && t_end.size() >= 3) begin
      for (int i = 0; i < 4; i++) chk("rr_owner", 32'(t_owner[i]), 32'(exp_own[i]));
      for (int i = 0; i < 3; i++) begin
        chk("rr_len", 32'(t_end[i] - t_start[i]), 32'd4);
        chk("rr_gap", 32'(t_start[i+1] - t_end[i]), 32'd2);
      end
    end else chk("rr_tenures", 32'(t_owner.size()), 32'd4);

    // Lone requester is re-granted after the gap
    step(4'b0000, 1, $urandom);
    clear_log();
    for (int i = 0; i < 20; i++) step(4'b0001, 0, $urandom);
    if (t_owner.size() >= 2) begin
      chk("lone_owner", 32'(t_owner[1]), 32'd0);
      chk("lone_period", 32'(t_start[1] - t_start[0]), 32'd6);
    end else chk("lone_tenures", 32'(t_owner.size()), 32'd2);

    // Reset mid-tenure of channel 3, then 0 must win first
    step(4'b0000, 1, $urandom);
    for (int i = 0; i < 3; i++) step(4'b1000, 0, $urandom);
    clear_log();
    step(4'b1001, 1, $urandom);
    for (int i = 0; i < 6; i++) step(4'b1001, 0, $urandom);
    if (t_owner.size() >= 1 && t_end.size() >= 1) begin
      chk("rst_mid_owner", 32'(t_owner[0]), 32'd0);
      chk("rst_mid_release", 32'(t_end[0] < t_start[0]), 32'd1);
    end else chk("rst_mid_seen", 32'(t_owner.size()), 32'd1);

    // Randomized traffic with occasional resets
    r = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(3) == 0) r[c] = 1'($urandom_range(1));
      end
      step(r, ($urandom_range(199) == 0), $urandom);
    end

    repeat (2) @(posedge clk);
    #2;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
